// File: rtl/seq_array_multiplier.sv
// Sequential shift-and-add unsigned multiplier that adds one partial-product row per clock, with valid/ready handshakes on both sides.
// Optional macro SEQ_ARRAY_MULTIPLIER_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier bits are all zero.
module seq_array_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic                 last_row;

  // acc_next already includes the current row, so product can load it on the final RUN edge
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  always_comb begin
    last_row = (cnt == CW'(WIDTH - 1));
`ifdef SEQ_ARRAY_MULTIPLIER_EARLY_TERM_EN
    if (mplier[WIDTH-1:1] == '0) begin
      last_row = 1'b1;
    end
`endif
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last_row) begin
            product <= acc_next;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Randomized self-checking bench for seq_array_multiplier at WIDTH=4 and WIDTH=8.
// Expected products and latencies come from plain arithmetic on the operands.
module tb_seq_array_multiplier;

  logic        clk;
  logic        rst_n;
  logic        sel_w8;
  logic        in_valid_drv;
  logic [7:0]  a_drv;
  logic [7:0]  b_drv;
  logic        out_ready;

  logic        in_valid4;
  logic        in_ready4;
  logic        out_valid4;
  logic [7:0]  product4;
  logic        in_valid8;
  logic        in_ready8;
  logic        out_valid8;
  logic [15:0] product8;

  logic        cur_in_ready;
  logic        cur_out_valid;
  logic [15:0] cur_product;

  int unsigned n_checks;
  int unsigned n_fail;

  assign in_valid4     = in_valid_drv && !sel_w8;
  assign in_valid8     = in_valid_drv && sel_w8;
  assign cur_in_ready  = sel_w8 ? in_ready8 : in_ready4;
  assign cur_out_valid = sel_w8 ? out_valid8 : out_valid4;
  assign cur_product   = sel_w8 ? product8 : {8'b0, product4};

  seq_array_multiplier #(.WIDTH(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid4),
    .in_ready (in_ready4),
    .a        (a_drv[3:0]),
    .b        (b_drv[3:0]),
    .out_valid(out_valid4),
    .out_ready(out_ready),
    .product  (product4)
  );

  seq_array_multiplier #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .a        (a_drv),
    .b        (b_drv),
    .out_valid(out_valid8),
    .out_ready(out_ready),
    .product  (product8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // RUN length: the full width, or with early termination the position of b's top set bit (at least one row)
  function automatic int unsigned refLatency(input int unsigned bv, input int unsigned w);
    int unsigned n;
    n = w;
`ifdef SEQ_ARRAY_MULTIPLIER_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < int'(w); i++) begin
      if (((bv >> i) & 1) != 0) n = i + 1;
    end
`endif
    return n;
  endfunction

  // One full transaction: accept, scramble the inputs during RUN, stall in DONE, then hand off
  task automatic applyStimulus(input bit w8, input int unsigned av, input int unsigned bv, input int unsigned stalls);
    int unsigned w, exp_prod, exp_lat, lat, guard;
    sel_w8   = w8;
    w        = w8 ? 8 : 4;
    exp_prod = av * bv;
    exp_lat  = refLatency(bv, w);
    guard    = 0;
    while (!cur_in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cur_in_ready) begin
      checkOutput("idle_timeout", 32'(cur_in_ready), 1);
      return;
    end
    a_drv        = 8'(av);
    b_drv        = 8'(bv);
    in_valid_drv = 1'b1;
    out_ready    = 1'($urandom);
    @(negedge clk);
    checkOutput("accepted", 32'(cur_in_ready), 0);
    lat = 0;
    while (!cur_out_valid && lat < 100) begin
      in_valid_drv = 1'($urandom);
      a_drv        = 8'($urandom);
      b_drv        = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", lat, exp_lat);
    if (!cur_out_valid) begin
      in_valid_drv = 1'b0;
      return;
    end
    for (int s = 0; s < int'(stalls); s++) begin
      out_ready = 1'b0;
      checkOutput("product_stall", 32'(cur_product), exp_prod);
      checkOutput("in_ready_in_done", 32'(cur_in_ready), 0);
      @(negedge clk);
      checkOutput("valid_held", 32'(cur_out_valid), 1);
    end
    out_ready    = 1'b1;
    in_valid_drv = 1'b1;
    a_drv        = 8'($urandom);
    b_drv        = 8'($urandom);
    checkOutput("product", 32'(cur_product), exp_prod);
    @(negedge clk);
    in_valid_drv = 1'b0;
    checkOutput("in_ready_after", 32'(cur_in_ready), 1);
    checkOutput("valid_after", 32'(cur_out_valid), 0);
  endtask

  always @(negedge clk) begin
    checkOutput("ready_valid_excl4", 32'(in_ready4 & out_valid4), 0);
    checkOutput("ready_valid_excl8", 32'(in_ready8 & out_valid8), 0);
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    sel_w8       = 1'b0;
    in_valid_drv = 1'b0;
    a_drv        = '0;
    b_drv        = '0;
    out_ready    = 1'b0;
    rst_n        = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready4), 1);
    checkOutput("reset_out_valid", 32'(out_valid4), 0);
    checkOutput("reset_product", 32'(product4), 0);
    checkOutput("reset_product8", 32'(product8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1'b0, 15, 15, 0);
    applyStimulus(1'b0, 9, 6, 10);
    applyStimulus(1'b0, 7, 1, 0);
    applyStimulus(1'b0, 0, 13, 1);

    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        applyStimulus(1'b0, ai, bi, $urandom_range(0, 3));
      end
    end

    // Abort 12*11 in its second RUN cycle; the product register still holds 225 from before
    sel_w8       = 1'b0;
    a_drv        = 8'd12;
    b_drv        = 8'd11;
    in_valid_drv = 1'b1;
    @(negedge clk);
    in_valid_drv = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid4), 0);
    checkOutput("abort_product", 32'(product4), 0);
    checkOutput("abort_in_ready", 32'(in_ready4), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("no_valid_after_abort", 32'(out_valid4), 0);
    end
    applyStimulus(1'b0, 3, 5, 1);

    applyStimulus(1'b1, 255, 255, 2);
    applyStimulus(1'b1, 1, 200, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
